// File: rtl/fb_pixel_streamer.sv
// Frame-buffer readout engine: walks a packed-pixel RAM word by word,
// unpacks each word lane by lane and streams the pixels out over valid/ready.
// Two word slots (output word + prefetch word) plus up to two reads in the
// RAM pipeline give gapless one-pixel-per-cycle output with one read every
// PIX_PER_WORD cycles.
module fb_pixel_streamer #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int ADDR_W       = 17,
    parameter int FRAME_PIX    = 307200
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic                          abort,
    output logic                          ram_rd,
    output logic [ADDR_W-1:0]             ram_addr,
    input  logic [PIX_W*PIX_PER_WORD-1:0] ram_data,
    output logic [PIX_W-1:0]              pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_last,
    output logic                          busy,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt
);

    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int WORDS  = FRAME_PIX / PIX_PER_WORD;
    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int PCNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
    localparam logic [PCNT_W-1:0] LAST_PIX  = PCNT_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // control state
    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;

    // RAM request pipeline: ram_rd_q is the strobe, ret_q marks the cycle
    // in which the matching data sits on ram_data
    logic                ram_rd_q, ram_rd_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ret_q, ret_d;

    // word slots and unpacking
    logic                out_v_q, out_v_d;
    logic [WORD_W-1:0]   out_word_q, out_word_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                pf_v_q, pf_v_d;
    logic [WORD_W-1:0]   pf_word_q, pf_word_d;
    logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;

    // registered stream outputs and status
    logic [PIX_W-1:0]    pix_data_q, pix_data_d;
    logic                pix_last_q, pix_last_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    // shared combinational terms
    logic                xfer;
    logic                last_xfer;
    logic                word_done;
    logic                start_accept;
    logic [2:0]          occupancy;
    logic                slot_free;
    logic [ADDR_W-1:0]   ptr_next;

    // Handshake decode and slot accounting. A read is only issued when the
    // words held plus the reads still in the RAM pipeline leave a slot free,
    // so returning data always has somewhere to land.
    always_comb begin
        xfer         = out_v_q && pix_ready;
        last_xfer    = xfer && pix_last_q;
        word_done    = xfer && (lane_q == LAST_LANE);
        start_accept = (state_q == IDLE) && start && !abort;
        occupancy    = 3'(out_v_q) + 3'(pf_v_q) + 3'(ram_rd_q) + 3'(ret_q);
        slot_free    = (occupancy < 3'd2);
        ptr_next     = (rd_ptr_q == LAST_WORD) ? '0 : rd_ptr_q + ADDR_W'(1);
    end

    // Next-state logic and read issue; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rd_ptr_d   = rd_ptr_q;
        ram_rd_d   = 1'b0;
        ram_addr_d = ram_addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Word 0 is requested straight away so it is on the
                    // RAM port the cycle after start.
                    mode_d     = mode;
                    ram_rd_d   = 1'b1;
                    ram_addr_d = '0;
                    rd_ptr_d   = (LAST_WORD == '0) ? '0 : ADDR_W'(1);
                    state_d    = (!mode && (LAST_WORD == '0)) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (slot_free) begin
                    ram_rd_d   = 1'b1;
                    ram_addr_d = rd_ptr_q;
                    rd_ptr_d   = ptr_next;
                    if (!mode_q && (rd_ptr_q == LAST_WORD)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            mode_d     = mode_q;
            rd_ptr_d   = rd_ptr_q;
            ram_rd_d   = 1'b0;
            ram_addr_d = ram_addr_q;
        end
    end

    // Word slot management: consume the presented pixel, promote the prefetch
    // word at a word boundary, then park returning RAM data in the first free
    // slot (output word if empty after this cycle, else prefetch).
    always_comb begin
        ret_d      = ram_rd_q;
        out_v_d    = out_v_q;
        out_word_d = out_word_q;
        lane_d     = lane_q;
        pf_v_d     = pf_v_q;
        pf_word_d  = pf_word_q;
        pix_cnt_d  = pix_cnt_q;

        if (xfer) begin
            pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + PCNT_W'(1);
            if (word_done) begin
                lane_d     = '0;
                out_v_d    = pf_v_q;
                out_word_d = pf_v_q ? pf_word_q : out_word_q;
                pf_v_d     = 1'b0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end

        if (ret_q) begin
            if (!out_v_d) begin
                out_v_d    = 1'b1;
                out_word_d = ram_data;
                lane_d     = '0;
            end else begin
                pf_v_d    = 1'b1;
                pf_word_d = ram_data;
            end
        end

        if (start_accept) begin
            pix_cnt_d = '0;
        end

        if (abort) begin
            ret_d     = 1'b0;
            out_v_d   = 1'b0;
            pf_v_d    = 1'b0;
            lane_d    = '0;
            pix_cnt_d = '0;
        end
    end

    // Output register inputs: the pixel shown next cycle is taken from the
    // next output word and lane, so nothing on the stream is combinational.
    always_comb begin
        pix_data_d = pix_data_q;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (lane_d == LANE_W'(i)) begin
                pix_data_d = out_word_d[i*PIX_W +: PIX_W];
            end
        end
        pix_last_d   = out_v_d && (pix_cnt_d == LAST_PIX);
        busy_d       = (state_d != IDLE);
        frame_done_d = last_xfer && !abort;
        frame_cnt_d  = frame_cnt_q + {15'd0, frame_done_d};
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            rd_ptr_q     <= '0;
            ram_rd_q     <= 1'b0;
            ram_addr_q   <= '0;
            ret_q        <= 1'b0;
            out_v_q      <= 1'b0;
            out_word_q   <= '0;
            lane_q       <= '0;
            pf_v_q       <= 1'b0;
            pf_word_q    <= '0;
            pix_cnt_q    <= '0;
            pix_data_q   <= '0;
            pix_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_rd_q     <= ram_rd_d;
            ram_addr_q   <= ram_addr_d;
            ret_q        <= ret_d;
            out_v_q      <= out_v_d;
            out_word_q   <= out_word_d;
            lane_q       <= lane_d;
            pf_v_q       <= pf_v_d;
            pf_word_q    <= pf_word_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_data_q   <= pix_data_d;
            pix_last_q   <= pix_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign ram_rd     = ram_rd_q;
    assign ram_addr   = ram_addr_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = out_v_q;
    assign pix_last   = pix_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fb_pixel_streamer.sv
// Self-checking bench for fb_pixel_streamer with a 16-pixel frame.
// A behavioural model tracks the expected pixel index, frame count and
// whether a frame is in progress; a vector table pins the single-frame timing.
module tb_fb_pixel_streamer;

    localparam int PIX_W     = 8;
    localparam int PPW       = 4;
    localparam int ADDR_W    = 17;
    localparam int FRAME_PIX = 16;

    logic              clk = 1'b0;
    logic              reset, start, mode, abort, pix_ready;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic [7:0]        pix_data;
    logic              pix_valid, pix_last, busy, frame_done;
    logic [15:0]       frame_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // behavioural model state
    int  m_idx    = 0;
    int  m_frames = 0;
    bit  m_active = 1'b0;
    bit  m_mode   = 1'b0;
    bit  pend_done = 1'b0;
    int  xfer_count = 0;
    int  done_seen  = 0;

    typedef struct {
        bit         st;
        bit         rdy;
        bit         exp_valid;
        bit         chk_data;
        logic [7:0] exp_data;
        bit         exp_last;
        bit         exp_done;
        bit         exp_busy;
        bit         chk_rd;
        bit         exp_rd;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[21];

    fb_pixel_streamer #(
        .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .ADDR_W(ADDR_W), .FRAME_PIX(FRAME_PIX)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // word i holds pixels 4i..4i+3, lane 0 in the LSBs
    function automatic logic [31:0] ramWord(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < PPW; j++) begin
            w[j*8 +: 8] = 8'(int'(a) * PPW + j);
        end
        return w;
    endfunction

    // one-cycle-latency synchronous RAM; garbage on the bus when not read
    always @(posedge clk) begin
        if (ram_rd) ram_data <= ramWord(ram_addr);
        else        ram_data <= $urandom;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetOutputs(input string pre);
        checkOutput({pre, "_valid"}, pix_valid, 0);
        checkOutput({pre, "_data"}, pix_data, 0);
        checkOutput({pre, "_last"}, pix_last, 0);
        checkOutput({pre, "_busy"}, busy, 0);
        checkOutput({pre, "_rd"}, ram_rd, 0);
        checkOutput({pre, "_addr"}, ram_addr, 0);
        checkOutput({pre, "_done"}, frame_done, 0);
        checkOutput({pre, "_cnt"}, frame_cnt, 0);
    endtask

    // Drive one cycle of inputs, advance the model through that cycle's
    // handshake, step the clock and check the next cycle's outputs.
    task automatic applyStimulus(input bit st, input bit md, input bit ab,
                                 input bit rdy, input bit rst_n);
        bit         was_active, xf, last_x, p_valid, p_disrupt;
        logic [7:0] p_data;
        logic       p_last;
        start = st; mode = md; abort = ab; pix_ready = rdy; reset = rst_n;
        was_active = m_active;
        xf = rst_n && (pix_valid === 1'b1) && rdy;
        if (xf) begin
            checkOutput("xfer_data", pix_data, m_idx);
            checkOutput("xfer_last", pix_last, (m_idx == FRAME_PIX - 1));
            xfer_count++;
        end
        last_x    = xf && (m_idx == FRAME_PIX - 1) && !ab;
        pend_done = last_x;
        if (xf) m_idx = (m_idx + 1) % FRAME_PIX;
        if (last_x) begin
            m_frames = (m_frames + 1) % 65536;
            if (!m_mode) m_active = 1'b0;
        end
        if (st && !was_active && !ab) begin
            m_active = 1'b1;
            m_mode   = md;
            m_idx    = 0;
        end
        if (ab) begin
            m_active = 1'b0;
            m_idx    = 0;
        end
        if (!rst_n) begin
            m_active  = 1'b0;
            m_idx     = 0;
            m_frames  = 0;
            pend_done = 1'b0;
        end
        p_valid   = (pix_valid === 1'b1);
        p_data    = pix_data;
        p_last    = pix_last;
        p_disrupt = ab || !rst_n;

        @(posedge clk);
        #1;
        cyc++;

        if (!p_disrupt && p_valid && !rdy) begin
            checkOutput("stall_valid", pix_valid, 1);
            checkOutput("stall_data", pix_data, p_data);
            checkOutput("stall_last", pix_last, p_last);
        end
        if (p_disrupt) begin
            checkOutput("disrupt_valid", pix_valid, 0);
            checkOutput("disrupt_rd", ram_rd, 0);
        end
        checkOutput("frame_done", frame_done, pend_done);
        checkOutput("frame_cnt", frame_cnt, m_frames);
        checkOutput("busy", busy, m_active);
        if (!m_active) checkOutput("idle_valid", pix_valid, 0);
        checkOutput("addr_range", (ram_addr <= 3), 1);
        if (frame_done === 1'b1) done_seen++;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkResetOutputs("rst");
        xfer_count = 0;
        done_seen  = 0;
    endtask

    task automatic runUntilIdle(input int bound, input bit rnd);
        int n;
        n = 0;
        while (m_active && n < bound) begin
            applyStimulus(0, 0, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1);
            n++;
        end
        checkOutput("idle_reached", busy, 0);
    endtask

    task automatic runUntilPixel(input int k, input int bound);
        int n;
        n = 0;
        while (!(pix_valid === 1'b1 && m_idx == k) && n < bound) begin
            applyStimulus(0, 0, 0, 1, 1);
            n++;
        end
        checkOutput("pixel_reached", (pix_valid === 1'b1 && m_idx == k), 1);
    endtask

    initial begin
        int s, first, last_c, n;

        // single-frame timing table, row r = cycle start+r
        for (int r = 0; r < 21; r++) begin
            vecs[r].st        = (r == 0);
            vecs[r].rdy       = 1'b1;
            vecs[r].exp_valid = (r >= 3 && r <= 18);
            vecs[r].chk_data  = (r >= 3 && r <= 18);
            vecs[r].exp_data  = 8'(r - 3);
            vecs[r].exp_last  = (r == 18);
            vecs[r].exp_done  = (r == 19);
            vecs[r].exp_busy  = (r >= 1 && r <= 18);
            vecs[r].chk_rd    = (r <= 1);
            vecs[r].exp_rd    = (r == 1);
            vecs[r].exp_cnt   = (r >= 19) ? 1 : 0;
        end

        start = 0; mode = 0; abort = 0; pix_ready = 1; reset = 0;

        // reset for cycles 0..2, idle until cycle 10
        while (cyc < 10) begin
            if (cyc == 2) checkResetOutputs("por");
            applyStimulus(0, 0, 0, 1, (cyc >= 3));
        end

        $display("[TB] single frame, ready high, start at cycle %0d", cyc);
        for (int r = 0; r < 21; r++) begin
            checkOutput("tbl_valid", pix_valid, vecs[r].exp_valid);
            if (vecs[r].chk_data) checkOutput("tbl_data", pix_data, vecs[r].exp_data);
            checkOutput("tbl_last", pix_last, vecs[r].exp_last);
            checkOutput("tbl_done", frame_done, vecs[r].exp_done);
            checkOutput("tbl_busy", busy, vecs[r].exp_busy);
            checkOutput("tbl_cnt", frame_cnt, vecs[r].exp_cnt);
            if (vecs[r].chk_rd) checkOutput("tbl_rd", ram_rd, vecs[r].exp_rd);
            if (vecs[r].chk_rd && vecs[r].exp_rd) checkOutput("tbl_addr", ram_addr, 0);
            applyStimulus(vecs[r].st, 0, 0, vecs[r].rdy, 1);
        end

        $display("[TB] single frame, random ready");
        doReset();
        applyStimulus(1, 0, 0, 1'($urandom_range(0, 1)), 1);
        runUntilIdle(400, 1);
        checkOutput("rnd_xfers", xfer_count, 16);
        checkOutput("rnd_cnt", frame_cnt, 1);

        $display("[TB] continuous mode, three frames");
        doReset();
        s = cyc; first = -1; last_c = -1; n = 0;
        applyStimulus(1, 1, 0, 1, 1);
        while (xfer_count < 48 && n < 200) begin
            if (first < 0 && pix_valid === 1'b1) first = cyc;
            applyStimulus(0, 0, 0, 1, 1);
            if (xfer_count == 48) last_c = cyc - 1;
            n++;
        end
        checkOutput("cont_first", first, s + 3);
        checkOutput("cont_gapless", last_c - first, 47);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("cont_done_count", done_seen, 3);
        checkOutput("cont_cnt", frame_cnt, 3);
        checkOutput("cont_abort_busy", busy, 0);

        $display("[TB] abort while pixel 6 stalled");
        doReset();
        applyStimulus(1, 0, 0, 1, 1);
        runUntilPixel(6, 40);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 0, 1);
        checkOutput("abort_valid", pix_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rd", ram_rd, 0);
        checkOutput("abort_cnt", frame_cnt, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 1);
        s = cyc; n = 0;
        applyStimulus(1, 0, 0, 1, 1);
        while (pix_valid !== 1'b1 && n < 20) begin
            applyStimulus(0, 0, 0, 1, 1);
            n++;
        end
        checkOutput("restart_latency", cyc - s, 3);
        checkOutput("restart_data", pix_data, 0);
        runUntilIdle(100, 0);
        checkOutput("restart_cnt", frame_cnt, 1);

        $display("[TB] reset mid-frame in continuous mode");
        doReset();
        applyStimulus(1, 1, 0, 1, 1);
        for (int k = 0; k < 24; k++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre_reset_cnt", frame_cnt, 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkResetOutputs("mid_rst");
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("rst_start_v1", pix_valid, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("rst_start_v2", pix_valid, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("rst_start_v3", pix_valid, 1);
        checkOutput("rst_start_data", pix_data, 0);
        runUntilIdle(100, 0);

        $display("[TB] start ignored while busy");
        doReset();
        applyStimulus(1, 0, 0, 1, 1);
        runUntilPixel(5, 40);
        applyStimulus(1, 1, 0, 1, 1);
        runUntilIdle(100, 0);
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("ign_xfers", xfer_count, 16);
        checkOutput("ign_cnt", frame_cnt, 1);
        checkOutput("ign_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
